// File: rtl/mac_layer_sequencer_pkg.sv
// mac_ctrl_pkg: state encodings and width helper shared by the MAC layer control logic.
package mac_ctrl_pkg;
  localparam int L_MAX = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;
  function automatic int clog2_min1(input int v);
    return v <= 2 ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/mac_layer_sequencer_if.sv
// mac_layer_sequencer_if: control bundle between the layer sequencer and its memories, accumulator and result file.
interface mac_layer_sequencer_if #(
  parameter int DW = 2,
  parameter int WW = 4,
  parameter int QW = 2
);
  logic start;
  logic [DW-1:0] x_addr;
  logic [WW-1:0] w_addr;
  logic mem_rd;
  logic acc_clear;
  logic acc_en;
  logic res_write;
  logic [QW-1:0] res_addr;
  logic res_ready;
  logic busy;
  logic done;
  modport master (
    input start, res_ready,
    output x_addr, w_addr, mem_rd, acc_clear, acc_en, res_write, res_addr, busy, done
  );
  modport slave (
    output start, res_ready,
    input x_addr, w_addr, mem_rd, acc_clear, acc_en, res_write, res_addr, busy, done
  );
endinterface

// File: rtl/mac_layer_sequencer_rd_valid_delay.sv
// rd_valid_delay: delays a read strobe by the memory latency so it lines up with returning data.
module rd_valid_delay #(
  parameter int L = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic v_i,
  output logic v_o
);
  logic [L-1:0] sr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= L'({sr_q, v_i});
  assign v_o = sr_q[L-1];
endmodule

// File: rtl/mac_layer_sequencer.sv
// mac_layer_sequencer: walks one layer of Q neurons x D inputs through read, accumulate and result write.
module mac_layer_sequencer
  import mac_ctrl_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 4,
  parameter int Q = 3,
  parameter int L = 1
) (
  input logic clk,
  input logic rst_n,
  mac_layer_sequencer_if.master bus
);
  localparam int DW = clog2_min1(D);
  localparam int QW = clog2_min1(Q);
  localparam int WW = clog2_min1(D * Q);
  if (N < 1 || D < 1 || Q < 1 || L < 1 || L > L_MAX) begin : g_bad_params
    $error("mac_layer_sequencer: illegal parameters");
  end
  state_t state_q, state_d;
  logic [DW-1:0] i_q, i_d;
  logic [QW-1:0] q_q, q_d;
  logic [2:0] c_q, c_d;
  logic issue, acc_en;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q <= '0;
      q_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      q_q <= q_d;
      c_q <= c_d;
    end
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    q_d = q_q;
    c_d = c_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_CLEAR;
        q_d = '0;
      end
      S_CLEAR: begin
        state_d = S_ISSUE;
        i_d = '0;
      end
      S_ISSUE: if (i_q == DW'(D - 1)) begin
        state_d = S_DRAIN;
        c_d = '0;
      end else i_d = i_q + 1'b1;
      S_DRAIN: if (c_q == 3'(L - 1)) state_d = S_WRITE;
      else c_d = c_q + 1'b1;
      // Last neuron leaves q at Q-1; wrap happens only through the next IDLE start.
      S_WRITE: if (bus.res_ready) begin
        state_d = q_q == QW'(Q - 1) ? S_DONE : S_CLEAR;
        q_d = q_q == QW'(Q - 1) ? q_q : q_q + 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign issue = state_q == S_ISSUE;
  rd_valid_delay #(.L(L)) u_rd_valid_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .v_i  (issue),
    .v_o  (acc_en)
  );
  assign bus.mem_rd = issue;
  assign bus.x_addr = issue ? i_q : '0;
  assign bus.w_addr = issue ? WW'(q_q) * WW'(D) + WW'(i_q) : '0;
  assign bus.acc_clear = state_q == S_CLEAR;
  assign bus.acc_en = acc_en;
  assign bus.res_write = state_q == S_WRITE;
  assign bus.res_addr = state_q == S_WRITE ? q_q : '0;
  assign bus.busy = state_q inside {S_CLEAR, S_ISSUE, S_DRAIN, S_WRITE, S_DONE};
  assign bus.done = state_q == S_DONE;
endmodule

// File: tb/tb_mac_layer_sequencer.sv
// tb_mac_layer_sequencer: scoreboard bench for the layer sequencer in a D4/Q3/L1 and a D1/Q1/L3 configuration.
module tb_mac_layer_sequencer;
  import mac_ctrl_pkg::*;
  localparam int D0 = 4, Q0 = 3, L0 = 1;
  localparam int D1 = 1, Q1 = 1, L1 = 3;
  typedef struct {int cyc; int a; int b;} ev_t;
  logic clk = 0;
  logic rst_n = 0;
  int edge_n = 0, base0 = 0, base1 = 0, rel0, rel1;
  int total = 0, passed = 0;
  bit stall0 = 0, prev_done0 = 0;
  ev_t rd0[$], acc0[$], wr0[$], dn0[$], rd1[$], acc1[$], wr1[$], dn1[$];
  mac_layer_sequencer_if #(.DW(clog2_min1(D0)), .WW(clog2_min1(D0 * Q0)), .QW(clog2_min1(Q0))) b0 ();
  mac_layer_sequencer_if #(.DW(clog2_min1(D1)), .WW(clog2_min1(D1 * Q1)), .QW(clog2_min1(Q1))) b1 ();
  mac_layer_sequencer #(.N(8), .D(D0), .Q(Q0), .L(L0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mac_layer_sequencer #(.N(8), .D(D1), .Q(Q1), .L(L1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  assign rel0 = edge_n - base0;
  assign rel1 = edge_n - base1;
  assign b0.res_ready = !(stall0 && rel0 >= 13 && rel0 <= 15);
  assign b1.res_ready = 1'b1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic pop(ref ev_t qq[$], output ev_t r);
    r = '{-1, -1, -1};
    if (qq.size() > 0) r = qq.pop_front();
  endtask
  function automatic int outs0();
    return int'({b0.x_addr, b0.w_addr, b0.mem_rd, b0.acc_clear, b0.acc_en, b0.res_write, b0.res_addr, b0.busy, b0.done});
  endfunction
  function automatic int outs1();
    return int'({b1.x_addr, b1.w_addr, b1.mem_rd, b1.acc_clear, b1.acc_en, b1.res_write, b1.res_addr, b1.busy, b1.done});
  endfunction
  // Expected events relative to the edge that samples start; stall extends neuron 1's WRITE.
  task automatic push_layer0(input int stall, input int cut);
    int t = 0;
    int w;
    for (int n = 0; n < Q0; n++) begin
      for (int i = 0; i < D0; i++) begin
        if (t + 1 + i < cut) rd0.push_back('{t + 1 + i, i, n * D0 + i});
        if (t + 1 + i + L0 < cut) acc0.push_back('{t + 1 + i + L0, 0, 0});
      end
      w = t + D0 + L0 + 1 + (n == 1 ? stall : 0);
      if (w < cut) wr0.push_back('{w, n, 0});
      t = w + 1;
    end
    if (t < cut) dn0.push_back('{t, 0, 0});
  endtask
  task automatic run0(input int stall, input bit repulse, input int cut);
    push_layer0(stall, cut);
    @(negedge clk);
    stall0 = stall > 0;
    b0.start = 1;
    base0 = edge_n + 1;
    @(negedge clk);
    b0.start = 0;
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      b0.start = repulse && rel0 == 8;
      if (rel0 == cut - 1) begin
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk("abort0_outputs_zero", outs0(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("idle0_after_abort", int'(b0.busy), 0);
        break;
      end
    end
    stall0 = 0;
  endtask
  always @(negedge clk) begin : mon0
    ev_t e;
    if (b0.mem_rd) begin
      pop(rd0, e);
      chk("rd0_cyc", rel0, e.cyc);
      chk("rd0_addr", int'(b0.x_addr) * 256 + int'(b0.w_addr), e.a * 256 + e.b);
    end
    if (b0.acc_en) begin
      pop(acc0, e);
      chk("acc0_cyc", rel0, e.cyc);
      chk("acc0_no_clear", int'(b0.acc_clear), 0);
    end
    if (b0.res_write && b0.res_ready) begin
      pop(wr0, e);
      chk("wr0_cyc", rel0, e.cyc);
      chk("wr0_addr", int'(b0.res_addr), e.a);
    end
    if (b0.res_write && !b0.res_ready)
      chk("stall0_hold", int'({b0.res_addr, b0.mem_rd, b0.acc_en, b0.acc_clear, b0.busy}), 17);
    if (b0.done) begin
      pop(dn0, e);
      chk("done0_cyc", rel0, e.cyc);
      chk("done0_busy", int'(b0.busy), 1);
    end
    if (prev_done0) chk("busy0_after_done", int'(b0.busy), 0);
    prev_done0 = b0.done;
  end
  always @(negedge clk) begin : mon1
    ev_t e;
    if (b1.mem_rd) begin
      pop(rd1, e);
      chk("rd1_cyc", rel1, e.cyc);
      chk("rd1_addr", int'(b1.x_addr) * 256 + int'(b1.w_addr), e.a * 256 + e.b);
    end
    if (b1.acc_en) begin
      pop(acc1, e);
      chk("acc1_cyc", rel1, e.cyc);
    end
    if (b1.res_write && b1.res_ready) begin
      pop(wr1, e);
      chk("wr1_cyc", rel1, e.cyc);
      chk("wr1_addr", int'(b1.res_addr), e.a);
    end
    if (b1.done) begin
      pop(dn1, e);
      chk("done1_cyc", rel1, e.cyc);
    end
  end
  initial begin
    b0.start = 0;
    b1.start = 0;
    @(negedge clk);
    chk("reset0_outputs", outs0(), 0);
    chk("reset1_outputs", outs1(), 0);
    @(negedge clk);
    rst_n = 1;
    run0(0, 0, 1000);
    run0(3, 0, 1000);
    run0(0, 1, 1000);
    run0(0, 0, 9);
    run0(0, 0, 1000);
    rd1.push_back('{1, 0, 0});
    acc1.push_back('{4, 0, 0});
    wr1.push_back('{5, 0, 0});
    dn1.push_back('{6, 0, 0});
    @(negedge clk);
    b1.start = 1;
    base1 = edge_n + 1;
    @(negedge clk);
    b1.start = 0;
    repeat (12) @(negedge clk);
    chk("left0", rd0.size() + acc0.size() + wr0.size() + dn0.size(), 0);
    chk("left1", rd1.size() + acc1.size() + wr1.size() + dn1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mac_layer_sequencer.md
Name: mac_layer_sequencer

Overview:
- Sequences the shared single-MAC neuron datapath through one full layer: Q neurons, each with D inputs.
- Issues x/weight memory reads, aligns the accumulate enable to read latency, clears the accumulator per neuron, writes each result under a ready handshake, and signals layer completion.
- Sits between the top-level start/done interface and the x/weight memories, accumulator and result register file.

Parameters:
- N, 8: datapath word width; reserved for datapath instantiation, unused inside the sequencer.
- D, 4: inputs per neuron (D ≥ 1).
- Q, 3: neurons per layer (Q ≥ 1).
- L, 1: x/weight memory read latency in cycles (1..4).
- DW, clog2(D) (min 1): x address width.
- QW, clog2(Q) (min 1): neuron index and result address width.
- WW, clog2(D*Q) (min 1): weight address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- x_addr  out  DW  x memory read address.
- w_addr  out  WW  weight memory read address.
- mem_rd  out  1  read strobe to both memories.
- acc_clear  out  1  synchronous accumulator clear.
- acc_en  out  1  accumulate x*w this cycle.
- res_write  out  1  result valid to result register file.
- res_addr  out  QW  result destination (neuron index).
- res_ready  in  1  result register file accepts this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle layer-complete pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters 0, delay line 0. Every output is 0 immediately: addresses, mem_rd, acc_clear, acc_en, res_write, res_addr, busy, done.
- Outputs decode from registered state/counters only; no combinational path from start to any output. The single exception is the WRITE exit, which depends on res_ready.
- States:
  - IDLE: start=1 -> CLEAR, with q=0.
  - CLEAR: acc_clear=1, i=0 -> ISSUE.
  - ISSUE: mem_rd=1, x_addr=i, w_addr=q*D+i. If i=D-1 -> DRAIN with drain counter=0; else i++.
  - DRAIN: mem_rd=0; stay L cycles -> WRITE.
  - WRITE: res_write=1, res_addr=q; hold until res_ready=1. On accept: q=Q-1 -> DONE, else q++ and -> CLEAR.
  - DONE: done=1 for one cycle -> IDLE.
- acc_en is mem_rd delayed by exactly L cycles through a shift register. It is high for exactly D cycles per neuron, never coincides with acc_clear, and the last acc_en cycle is the final DRAIN cycle.
- Timing with res_ready held high: edge sampling start is edge 0. Neuron n's CLEAR is entered at edge n*(D+L+2). DONE is entered at edge Q*(D+L+2).
- Each neuron takes D+L+2 cycles, plus any WRITE stall cycles.
- Boundary conditions:
  - res_ready low: WRITE holds; res_write, res_addr and all other outputs stay stable; no new reads are issued.
  - start high while busy: ignored, no restart.
  - start still high in the cycle after DONE: IDLE samples it and begins a new layer on the next edge.
  - D=1: ISSUE lasts exactly one cycle.
  - Q=1: the first WRITE accept goes straight to DONE.
  - q and i never exceed Q-1 and D-1; wrap is via state exit, not counter overflow.
  - rst asserted mid-layer: immediate abort, outputs 0, no done pulse. After rst release, the block waits in IDLE for start.
- Unused state encodings -> IDLE on next edge, all outputs 0.

Decomposition:
- Shared package mac_ctrl_pkg holds:
  - state encodings for IDLE, CLEAR, ISSUE, DRAIN, WRITE, DONE;
  - a clog2-style width helper used for DW, QW, WW.
- Sub-module rd_valid_delay (parameter L, async active-low rst) implements the mem_rd-to-acc_en shift register. It is reused by any later datapath needing latency-aligned valids.

Test Plan:
- Reset then start pulse with D=4, L=1, Q=3, res_ready=1:
  - mem_rd high at edges 1-4, 8-11, 15-18; acc_en one cycle later each time.
  - res_write at edges 6, 13, 20 with res_addr 0, 1, 2.
  - done entered at edge 21; busy low at edge 22.
- Address check in the same run: x_addr 0,1,2,3 per neuron; w_addr 0-3, 4-7, 8-11.
- res_ready held low for 3 cycles on neuron 1:
  - WRITE holds with res_write=1, res_addr=1, no mem_rd.
  - Neuron 2 CLEAR follows the accept edge; done is 3 edges later (edge 24).
- start pulsed again during ISSUE of neuron 1: no effect; single done at edge 21.
- rst driven low at edge 9: all outputs 0 asynchronously, no done. After release plus a start pulse, the full sequence restarts from q=0.
- L=3, D=1, Q=1: mem_rd at edge 1, acc_en at edge 4, res_write at edge 5, done at edge 6.
